uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receive stage; sits directly downstream of baud_gen. Consumes the
//  baud_gen tick (b_clk, 1-clk pulse at 16x the bit rate) as a sampling
//  strobe, oversamples the serial line and deserialises 8N1 frames.
//  Delivers each byte through a one-entry valid/ready holding register and
//  flags framing and overrun errors.
// PARAMETERS
//  DBIT     8   data bits per frame, LSB first; legal range 5..8
//  SB_TICK  16  s_tick count for the stop bit (16 = 1 stop bit)
// PORTS
//  clk          in   1     system clock; all logic on posedge
//  rst_n        in   1     asynchronous, active-low reset
//  s_tick       in   1     sample strobe from baud_gen b_clk, 16x bit rate
//  rx           in   1     serial input, asynchronous, idle high
//  rx_data      out  DBIT  received byte, stable while rx_valid=1
//  rx_valid     out  1     rx_data holds an unconsumed byte
//  rx_ready     in   1     consumer accepts rx_data when rx_valid & rx_ready
//  busy         out  1     1 whenever FSM is not in IDLE
//  frame_err    out  1     1-clk pulse: stop bit sampled low
//  overrun_err  out  1     1-clk pulse: new byte overwrote an unconsumed one
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=IDLE, counters=0, shift reg=0, sync FFs=1,
//   rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun_err=0.
//  rx passes through a 2-FF synchroniser (rx_s); FSM only sees rx_s.
//  All FSM advances, except IDLE->START, happen only in cycles with s_tick=1.
//  Counters: s (5b, tick count), n (3b, bit index), b (DBIT shift reg).
//  IDLE:  rx_s==0 -> START, s<=0 (no tick needed).
//  START: tick & s==7: rx_s==0 -> DATA, s<=0, n<=0; rx_s==1 -> IDLE
//         (glitch rejected, no error, no output). tick & s!=7: s<=s+1.
//  DATA:  tick & s==15: s<=0, b<={rx_s,b[DBIT-1:1]};
//         n==DBIT-1 -> STOP, else n<=n+1. tick & s!=15: s<=s+1.
//  STOP:  tick & s==SB_TICK-1: -> IDLE; rx_s==1 -> deliver b; rx_s==0 ->
//         frame_err=1 for one clk, byte discarded, rx_valid unchanged.
//         tick & s!=SB_TICK-1: s<=s+1.
//  Samples land mid-bit; frame returns to IDLE at mid stop bit, so a
//   back-to-back start edge is caught.
//  Deliver: rx_data<=b, rx_valid<=1 on the clk after the final stop tick.
//  Handshake: rx_valid & rx_ready -> rx_valid<=0 next clk (unless deliver).
//  Simultaneous deliver and accept: rx_valid stays 1, new data, no overrun.
//  Deliver while rx_valid=1 and rx_ready=0: rx_data overwritten,
//   rx_valid stays 1, overrun_err=1 for one clk.
//  Break (rx held low): frame_err each frame time, FSM re-enters START
//   right after IDLE; no data delivered until the line returns high.
//  s_tick ignored in IDLE; ticks arriving early in a frame are not special.
//  Reset mid-frame: partial byte lost, outputs return to reset values.
//  Integration: baud_gen DIVxR = f_clk/(16*baud) - 1, b_en=1.
// TESTING (bench: baud_gen DIVxR=3 -> tick every 4 clk, 64 clk/bit)
//  1 frame 0xA5, rx_ready=1 -> one rx_valid pulse, rx_data=0xA5,
//    frame_err=0, overrun_err=0, busy low after mid stop bit.
//  2 rx low for 20 clk then high (shorter than 8 ticks=32 clk)
//    -> FSM back to IDLE, no rx_valid, no frame_err.
//  3 frame 0x3C with stop bit driven 0 -> frame_err pulse, rx_valid stays 0.
//  4 rx_ready=0; frames 0x11 then 0x22 -> rx_data=0x22, one overrun_err
//    pulse; set rx_ready=1 -> rx_valid clears next clk.
//  5 back-to-back frames 0x00,0xFF,0x55 with no idle gap, rx_ready=1
//    -> three deliveries in order, no errors.
//  6 rst_n low mid DATA of 0x5A, release, send 0xC3 -> only 0xC3 delivered.

Source files
------------

// File: rtl/uart_rx_if.sv
// Valid/ready delivery channel carrying received bytes out of uart_rx.
// master = byte producer (uart_rx), slave = consumer.
interface uart_rx_if #(
   parameter int DBIT = 8
);
   logic [DBIT-1:0] rx_data;
   logic            rx_valid;
   logic            rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with a one-entry valid/ready holding
// register and framing/overrun error pulses.
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_tick,
   input  logic        rx,
   uart_rx_if.master   rx_if,
   output logic        busy,
   output logic        frame_err,
   output logic        overrun_err
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q;
   logic [4:0]      s_q;
   logic [2:0]      n_q;
   logic [DBIT-1:0] b_q;
   logic [DBIT-1:0] data_q;
   logic            valid_q;
   logic            ferr_q;
   logic            ovr_q;
   logic            sync_q;
   logic            rx_s_q;
   logic            stop_done_d;

   // Final stop-bit tick: the frame is complete this cycle.
   assign stop_done_d = (state_q == STOP) && s_tick && (s_q == 5'(SB_TICK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         sync_q <= rx;
         rx_s_q <= sync_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         if (valid_q && rx_if.rx_ready) valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_q <= START;
                  s_q     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_q == 5'd7) begin
                     // Line back high at mid start bit: treat as a glitch.
                     if (!rx_s_q) begin
                        state_q <= DATA;
                        s_q     <= '0;
                        n_q     <= '0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     s_q <= s_q + 5'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_q == 5'd15) begin
                     s_q <= '0;
                     b_q <= {rx_s_q, b_q[DBIT-1:1]};
                     if (n_q == 3'(DBIT - 1)) state_q <= STOP;
                     else                     n_q     <= n_q + 3'd1;
                  end else begin
                     s_q <= s_q + 5'd1;
                  end
               end
            end
            STOP: begin
               if (s_tick && s_q != 5'(SB_TICK - 1)) s_q <= s_q + 5'd1;
               if (stop_done_d) begin
                  state_q <= IDLE;
                  if (rx_s_q) begin
                     data_q  <= b_q;
                     valid_q <= 1'b1;
                     // Pending byte not being taken this cycle is lost.
                     if (valid_q && !rx_if.rx_ready) ovr_q <= 1'b1;
                  end else begin
                     ferr_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_if.rx_data  = data_q;
   assign rx_if.rx_valid = valid_q;
   assign busy           = (state_q != IDLE);
   assign frame_err      = ferr_q;
   assign overrun_err    = ovr_q;

endmodule
